axil_reg_bridge: RTL and testbench

AXI4-Lite slave that translates bus writes into per-register write-enable pulses and bus reads into readback of register values. It sits between the system interconnect and a bank of `RW_REG` instances. It drives each register's `WEN`/`VALUE_IN` and collects each `VALUE_OUT`, so software can read and overwrite the register bank.

---
 rtl/axil_pkg.sv | 18 +
 rtl/axil_strb_merge.sv | 20 ++
 rtl/axil_reg_bridge.sv | 203 ++++++++++++++++++++
 tb/tb_axil_reg_bridge.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response codes and FSM state encodings for the register bridge.
package axil_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_UPDATE = 2'd1,
    W_RESP   = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axil_strb_merge.sv
// Byte-lane merge: each lane whose strobe bit is set takes the new data byte,
// every other lane keeps the old value byte.
module axil_strb_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_value,
  input  logic [DATA_WIDTH-1:0]   new_data,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [DATA_WIDTH-1:0]   merged
);

  // Select each byte lane independently from new or old data.
  always_comb begin
    merged = old_value;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      if (strb[b]) merged[b*8 +: 8] = new_data[b*8 +: 8];
    end
  end

endmodule

// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave fronting a bank of RW registers. Writes become a single-cycle
// one-hot REG_WEN pulse carrying a byte-merged value; reads return the selected
// REG_VALUE_OUT slice. Read and write paths are independent FSMs.
//
// Handshake rule on every channel: a transfer happens on the rising clock edge
// where VALID and READY are both high. A source holds VALID and its payload
// stable until that edge; here AWREADY/WREADY/ARREADY depend only on FSM state,
// and BVALID/RVALID with their payloads stay stable until BREADY/RREADY.
module axil_reg_bridge
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS   = 8
) (
  input  logic                           CLK,
  input  logic                           RSTN,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS-1:0]            REG_WEN,
  output logic [DATA_WIDTH-1:0]          REG_VALUE_IN,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] REG_VALUE_OUT,
  output wr_state_t                      dbg_wr_state,
  output rd_state_t                      dbg_rd_state
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;

  // Byte-offset address bits never select anything; they are ignored by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0]};

  // ---------------------------------------------------------------- write path
  wr_state_t             wr_state, wr_next;
  logic                  aw_got, w_got;
  logic                  aw_hs, w_hs;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  logic                  wr_in_range;
  logic [DATA_WIDTH-1:0] wr_old;
  logic [DATA_WIDTH-1:0] wr_merged;

  assign wr_in_range  = 32'(wr_idx) < 32'(NUM_REGS);
  assign dbg_wr_state = wr_state;

  // Current value of the register targeted by the captured write address.
  always_comb begin
    wr_old = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(wr_idx) == i) wr_old = REG_VALUE_OUT[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  axil_strb_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_strb_merge (
    .old_value (wr_old),
    .new_data  (w_data),
    .strb      (w_strb),
    .merged    (wr_merged)
  );

  // Write FSM state register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) wr_state <= W_IDLE;
    else       wr_state <= wr_next;
  end

  // Write FSM next state and outputs; AW and W are captured independently in idle.
  always_comb begin
    wr_next      = wr_state;
    AWREADY      = 1'b0;
    WREADY       = 1'b0;
    aw_hs        = 1'b0;
    w_hs         = 1'b0;
    BVALID       = 1'b0;
    BRESP        = AXI_RESP_OKAY;
    REG_WEN      = '0;
    REG_VALUE_IN = '0;
    case (wr_state)
      W_IDLE: begin
        AWREADY = !aw_got;
        WREADY  = !w_got;
        aw_hs   = AWVALID && !aw_got;
        w_hs    = WVALID && !w_got;
        if ((aw_got || aw_hs) && (w_got || w_hs)) wr_next = W_UPDATE;
      end
      W_UPDATE: begin
        if (wr_in_range) begin
          for (int i = 0; i < NUM_REGS; i++) REG_WEN[i] = (32'(wr_idx) == i);
          REG_VALUE_IN = wr_merged;
        end
        wr_next = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        BRESP  = wr_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        if (BREADY) wr_next = W_IDLE;
      end
      default: wr_next = W_IDLE;
    endcase
  end

  // Capture AW/W payloads; the index is held through the response for BRESP.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      wr_idx <= '0;
      w_data <= '0;
      w_strb <= '0;
    end else begin
      if (aw_hs) begin
        wr_idx <= AWADDR[ADDR_WIDTH-1:ADDR_LSB];
        aw_got <= 1'b1;
      end
      if (w_hs) begin
        w_data <= WDATA;
        w_strb <= WSTRB;
        w_got  <= 1'b1;
      end
      if (wr_state == W_UPDATE) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
    end
  end

  // ----------------------------------------------------------------- read path
  rd_state_t             rd_state, rd_next;
  logic                  ar_hs;
  logic [IDX_W-1:0]      rd_idx;
  logic                  rd_in_range;
  logic [DATA_WIDTH-1:0] rd_sel;

  assign rd_idx       = ARADDR[ADDR_WIDTH-1:ADDR_LSB];
  assign rd_in_range  = 32'(rd_idx) < 32'(NUM_REGS);
  assign dbg_rd_state = rd_state;

  // Readback mux over the packed register values.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(rd_idx) == i) rd_sel = REG_VALUE_OUT[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Read FSM state register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) rd_state <= R_IDLE;
    else       rd_state <= rd_next;
  end

  // Read FSM next state and handshake outputs.
  always_comb begin
    rd_next = rd_state;
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    ar_hs   = 1'b0;
    case (rd_state)
      R_IDLE: begin
        ARREADY = 1'b1;
        ar_hs   = ARVALID;
        if (ARVALID) rd_next = R_DATA;
      end
      R_DATA: begin
        RVALID = 1'b1;
        if (RREADY) rd_next = R_IDLE;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  // Register read data and response at the AR handshake; held while RVALID waits.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      RDATA <= '0;
      RRESP <= AXI_RESP_OKAY;
    end else if (ar_hs) begin
      RDATA <= rd_in_range ? rd_sel : '0;
      RRESP <= rd_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
    end
  end

endmodule

// File: tb/tb_axil_reg_bridge.sv
// Directed bench for axil_reg_bridge with a behavioural RW register bank.
module tb_axil_reg_bridge;
  import axil_pkg::*;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NR = 8;

  logic          CLK, RSTN;
  logic [AW-1:0] AWADDR, ARADDR;
  logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RVALID, RREADY;
  logic [DW-1:0] WDATA, RDATA, REG_VALUE_IN;
  logic [3:0]    WSTRB;
  logic [1:0]    BRESP, RRESP;
  logic [NR-1:0] REG_WEN;
  logic [NR*DW-1:0] REG_VALUE_OUT;
  wr_state_t     dbg_wr_state;
  rd_state_t     dbg_rd_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic          bank_clr;
  logic [DW-1:0] bank [NR];

  axil_reg_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .REG_WEN(REG_WEN), .REG_VALUE_IN(REG_VALUE_IN), .REG_VALUE_OUT(REG_VALUE_OUT),
    .dbg_wr_state(dbg_wr_state), .dbg_rd_state(dbg_rd_state)
  );

  // clock / cycle counter
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // RW register bank: loads REG_VALUE_IN on its WEN bit; not reset by RSTN
  always @(posedge CLK) begin
    for (int i = 0; i < NR; i++) begin
      if (bank_clr) bank[i] <= '0;
      else if (REG_WEN[i]) bank[i] <= REG_VALUE_IN;
    end
  end

  always_comb begin
    REG_VALUE_OUT = '0;
    for (int i = 0; i < NR; i++) REG_VALUE_OUT[i*DW +: DW] = bank[i];
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // driver: AW and W together, BREADY high; reports what the register side saw
  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [3:0] strb, output logic [NR-1:0] wen,
                          output logic [DW-1:0] vin, output int wen_cycles,
                          output logic [1:0] resp, output int b_cyc);
    bit aw_done, w_done;
    int n;
    wen = '0; vin = '0; wen_cycles = 0; resp = 2'b11; b_cyc = -1;
    aw_done = 0; w_done = 0; n = 0;
    AWADDR = addr; WDATA = data; WSTRB = strb;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      if (AWVALID && AWREADY) aw_done = 1;
      if (WVALID && WREADY) w_done = 1;
      tick(); n++;
      if (aw_done) AWVALID = 1'b0;
      if (w_done) WVALID = 1'b0;
    end
    while (!BVALID && n < 40) begin
      if (REG_WEN != '0) begin wen |= REG_WEN; vin = REG_VALUE_IN; wen_cycles++; end
      tick(); n++;
    end
    checks++;
    if (!BVALID) begin
      errors++;
      $display("FAIL write_timeout addr=%h: BVALID=%b required 1", addr, BVALID);
      AWVALID = 1'b0; WVALID = 1'b0;
    end else begin
      if (REG_WEN != '0) wen_cycles++;
      resp = BRESP; b_cyc = cyc;
      tick();
    end
  endtask

  // driver: single read with RREADY high
  task automatic do_read(input logic [AW-1:0] addr, output logic [DW-1:0] d,
                         output logic [1:0] r, output int lat, output int r_cyc);
    int n;
    d = '0; r = 2'b11; lat = 0; r_cyc = -1; n = 0;
    ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b1;
    while (!ARREADY && n < 20) begin tick(); n++; end
    tick(); ARVALID = 1'b0; lat = 1;
    while (!RVALID && lat < 20) begin tick(); lat++; end
    checks++;
    if (!RVALID) begin
      errors++;
      $display("FAIL read_timeout addr=%h: RVALID=%b required 1", addr, RVALID);
    end else begin
      d = RDATA; r = RRESP; r_cyc = cyc;
      tick();
    end
  endtask

  task automatic test_reset();
    RSTN = 1'b0; bank_clr = 1'b1;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b1;
    ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b1;
    repeat (3) tick();
    RSTN = 1'b1; bank_clr = 1'b0;
    tick();
    checks++; if ({BVALID, RVALID} !== 2'b00) begin errors++; $display("FAIL reset_valids got %b want 00", {BVALID, RVALID}); end
    checks++; if ({BRESP, RRESP} !== 4'b0000) begin errors++; $display("FAIL reset_resps got %b want 0000", {BRESP, RRESP}); end
    checks++; if (RDATA !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", RDATA); end
    checks++; if (REG_WEN !== 8'h00) begin errors++; $display("FAIL reset_wen got %h want 00", REG_WEN); end
    checks++; if (REG_VALUE_IN !== 32'h0) begin errors++; $display("FAIL reset_value_in got %h want 0", REG_VALUE_IN); end
    checks++; if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin errors++; $display("FAIL reset_readies got %b want 111", {AWREADY, WREADY, ARREADY}); end
    checks++; if (dbg_wr_state !== W_IDLE || dbg_rd_state !== R_IDLE) begin errors++; $display("FAIL reset_states got %0d/%0d want 0/0", dbg_wr_state, dbg_rd_state); end
  endtask

  task automatic test_write_basic();
    logic [DW-1:0] d; logic [1:0] r; int lat, rc;
    BREADY = 1'b1; AWADDR = 8'h04; WDATA = 32'hDEADBEEF; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1;
    checks++; if ({AWREADY, WREADY} !== 2'b11) begin errors++; $display("FAIL basic_ready got %b want 11", {AWREADY, WREADY}); end
    tick(); AWVALID = 1'b0; WVALID = 1'b0;
    checks++; if (REG_WEN !== 8'b0000_0010) begin errors++; $display("FAIL basic_wen_t1 got %b want 00000010", REG_WEN); end
    checks++; if (REG_VALUE_IN !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_value_in got %h want deadbeef", REG_VALUE_IN); end
    checks++; if (BVALID !== 1'b0) begin errors++; $display("FAIL basic_bvalid_t1 got %b want 0", BVALID); end
    tick();
    checks++; if (REG_WEN !== 8'h00) begin errors++; $display("FAIL basic_wen_t2 got %b want 0", REG_WEN); end
    checks++; if ({BVALID, BRESP} !== 3'b100) begin errors++; $display("FAIL basic_bresp_t2 got %b want 100", {BVALID, BRESP}); end
    checks++; if (bank[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_reg1 got %h want deadbeef", bank[1]); end
    tick();
    checks++; if ({BVALID, AWREADY, WREADY} !== 3'b011) begin errors++; $display("FAIL basic_done got %b want 011", {BVALID, AWREADY, WREADY}); end
    do_read(8'h04, d, r, lat, rc);
    checks++; if (d !== 32'hDEADBEEF || r !== AXI_RESP_OKAY) begin errors++; $display("FAIL basic_read got %h/%b want deadbeef/00", d, r); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL basic_read_latency got %0d want 1", lat); end
  endtask

  task automatic test_strobe();
    logic [NR-1:0] w; logic [DW-1:0] v, d; logic [1:0] r; int wc, bc, lat, rc;
    do_write(8'h0C, 32'h11223344, 4'hF, w, v, wc, r, bc);
    checks++; if (w !== 8'h08 || bank[3] !== 32'h11223344) begin errors++; $display("FAIL strb_preload got wen=%h reg3=%h want 08/11223344", w, bank[3]); end
    do_write(8'h0C, 32'hAABBCCDD, 4'b0101, w, v, wc, r, bc);
    checks++; if (v !== 32'h11BB33DD) begin errors++; $display("FAIL strb_merge got %h want 11bb33dd", v); end
    checks++; if (w !== 8'h08 || wc !== 1 || r !== AXI_RESP_OKAY) begin errors++; $display("FAIL strb_wen got %h/%0d/%b want 08/1/00", w, wc, r); end
    do_read(8'h0C, d, r, lat, rc);
    checks++; if (d !== 32'h11BB33DD) begin errors++; $display("FAIL strb_readback got %h want 11bb33dd", d); end
    do_write(8'h0C, 32'hFFFFFFFF, 4'b0000, w, v, wc, r, bc);
    checks++; if (w !== 8'h08 || v !== 32'h11BB33DD || r !== AXI_RESP_OKAY) begin errors++; $display("FAIL strb_zero got %h/%h/%b want 08/11bb33dd/00", w, v, r); end
    checks++; if (bank[3] !== 32'h11BB33DD) begin errors++; $display("FAIL strb_zero_reg got %h want 11bb33dd", bank[3]); end
  endtask

  task automatic test_w_before_aw();
    BREADY = 1'b1; AWVALID = 1'b0; AWADDR = 8'h00;
    WDATA = 32'hCAFEF00D; WSTRB = 4'hF; WVALID = 1'b1;
    checks++; if ({AWREADY, WREADY} !== 2'b11) begin errors++; $display("FAIL wfirst_ready got %b want 11", {AWREADY, WREADY}); end
    tick(); WVALID = 1'b0;
    checks++; if ({AWREADY, WREADY} !== 2'b10) begin errors++; $display("FAIL wfirst_after_w got %b want 10", {AWREADY, WREADY}); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ({AWREADY, REG_WEN} !== 9'h100) begin errors++; $display("FAIL wfirst_wait%0d got %h want 100", i, {AWREADY, REG_WEN}); end
    end
    AWVALID = 1'b1;
    tick(); AWVALID = 1'b0;
    checks++; if (REG_WEN !== 8'h01 || REG_VALUE_IN !== 32'hCAFEF00D) begin errors++; $display("FAIL wfirst_wen got %h/%h want 01/cafef00d", REG_WEN, REG_VALUE_IN); end
    tick();
    checks++; if ({BVALID, BRESP} !== 3'b100) begin errors++; $display("FAIL wfirst_bresp got %b want 100", {BVALID, BRESP}); end
    tick();
    checks++; if (bank[0] !== 32'hCAFEF00D) begin errors++; $display("FAIL wfirst_reg0 got %h want cafef00d", bank[0]); end
  endtask

  task automatic test_out_of_range();
    logic [NR-1:0] w; logic [DW-1:0] v, d; logic [1:0] r; int wc, bc, lat, rc;
    do_write(8'h20, 32'h12121212, 4'hF, w, v, wc, r, bc);
    checks++; if (wc !== 0 || w !== 8'h00) begin errors++; $display("FAIL oor_wen got %h/%0d want 00/0", w, wc); end
    checks++; if (r !== AXI_RESP_SLVERR) begin errors++; $display("FAIL oor_bresp got %b want 10", r); end
    do_read(8'h20, d, r, lat, rc);
    checks++; if (d !== 32'h0 || r !== AXI_RESP_SLVERR) begin errors++; $display("FAIL oor_read got %h/%b want 0/10", d, r); end
    do_write(8'h1C, 32'h77770007, 4'hF, w, v, wc, r, bc);
    checks++; if (w !== 8'h80 || r !== AXI_RESP_OKAY) begin errors++; $display("FAIL last_reg_write got %h/%b want 80/00", w, r); end
    do_read(8'h1C, d, r, lat, rc);
    checks++; if (d !== 32'h77770007 || r !== AXI_RESP_OKAY) begin errors++; $display("FAIL last_reg_read got %h/%b want 77770007/00", d, r); end
    do_read(8'h07, d, r, lat, rc);
    checks++; if (d !== 32'hDEADBEEF || r !== AXI_RESP_OKAY) begin errors++; $display("FAIL low_bits_read got %h/%b want deadbeef/00", d, r); end
  endtask

  task automatic test_stall();
    logic [NR-1:0] w; logic [DW-1:0] v, d; logic [1:0] r; int wc, bc, lat, rc;
    BREADY = 1'b0; AWADDR = 8'h08; WDATA = 32'h12345678; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1;
    tick(); AWVALID = 1'b0; WVALID = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      checks++; if ({BVALID, BRESP, AWREADY, WREADY} !== 5'b10000) begin errors++; $display("FAIL bstall%0d got %b want 10000", i, {BVALID, BRESP, AWREADY, WREADY}); end
      tick();
    end
    BREADY = 1'b1;
    tick();
    checks++; if ({BVALID, AWREADY, WREADY} !== 3'b011 || bank[2] !== 32'h12345678) begin errors++; $display("FAIL bstall_release got %b/%h want 011/12345678", {BVALID, AWREADY, WREADY}, bank[2]); end
    ARADDR = 8'h08; ARVALID = 1'b1; RREADY = 1'b0;
    tick(); ARVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({RVALID, ARREADY, RRESP} !== 4'b1000 || RDATA !== 32'h12345678) begin errors++; $display("FAIL rstall%0d got %b/%h want 1000/12345678", i, {RVALID, ARREADY, RRESP}, RDATA); end
      tick();
    end
    do_write(8'h08, 32'h9ABCDEF0, 4'hF, w, v, wc, r, bc);
    for (int i = 5; i < 10; i++) begin
      checks++; if ({RVALID, ARREADY, RRESP} !== 4'b1000 || RDATA !== 32'h12345678) begin errors++; $display("FAIL rstall%0d got %b/%h want 1000/12345678", i, {RVALID, ARREADY, RRESP}, RDATA); end
      tick();
    end
    RREADY = 1'b1;
    tick();
    checks++; if ({RVALID, ARREADY} !== 2'b01) begin errors++; $display("FAIL rstall_release got %b want 01", {RVALID, ARREADY}); end
    do_read(8'h08, d, r, lat, rc);
    checks++; if (d !== 32'h9ABCDEF0) begin errors++; $display("FAIL rstall_newval got %h want 9abcdef0", d); end
  endtask

  task automatic test_back_to_back();
    logic [NR-1:0] w; logic [DW-1:0] v, d; logic [1:0] r; int wc, lat, bc, prev;
    logic [DW-1:0] vals [3];
    vals[0] = 32'h44440004; vals[1] = 32'h55550005; vals[2] = 32'h66660006;
    prev = -1;
    for (int i = 0; i < 3; i++) begin
      do_write(8'(8'h10 + 4 * i), vals[i], 4'hF, w, v, wc, r, bc);
      checks++; if (w !== 8'(8'h10 << i) || r !== AXI_RESP_OKAY) begin errors++; $display("FAIL b2b_write%0d got %h/%b want %h/00", i, w, r, 8'(8'h10 << i)); end
      if (i > 0) begin
        checks++; if (bc - prev !== 3) begin errors++; $display("FAIL b2b_write_period%0d got %0d want 3", i, bc - prev); end
      end
      prev = bc;
    end
    prev = -1;
    for (int i = 0; i < 3; i++) begin
      do_read(8'(8'h10 + 4 * i), d, r, lat, bc);
      checks++; if (d !== vals[i] || r !== AXI_RESP_OKAY) begin errors++; $display("FAIL b2b_read%0d got %h/%b want %h/00", i, d, r, vals[i]); end
      if (i > 0) begin
        checks++; if (bc - prev !== 2) begin errors++; $display("FAIL b2b_read_period%0d got %0d want 2", i, bc - prev); end
      end
      prev = bc;
    end
  endtask

  task automatic test_reset_mid();
    BREADY = 1'b1; AWADDR = 8'h14; WDATA = 32'hFFFFFFFF; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1;
    tick(); AWVALID = 1'b0; WVALID = 1'b0;
    checks++; if (REG_WEN !== 8'h20) begin errors++; $display("FAIL rstmid_update got %h want 20", REG_WEN); end
    #2 RSTN = 1'b0;
    #1;
    checks++; if (REG_WEN !== 8'h00) begin errors++; $display("FAIL rstmid_wen_drop got %h want 00", REG_WEN); end
    tick();
    RSTN = 1'b1;
    tick();
    checks++; if ({BVALID, AWREADY, WREADY, ARREADY} !== 4'b0111 || REG_WEN !== 8'h00) begin errors++; $display("FAIL rstmid_idle got %b/%h want 0111/00", {BVALID, AWREADY, WREADY, ARREADY}, REG_WEN); end
    checks++; if (bank[5] !== 32'h55550005) begin errors++; $display("FAIL rstmid_reg5 got %h want 55550005", bank[5]); end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_strobe();
    test_w_before_aw();
    test_out_of_range();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
